alu_mul: RTL and testbench

- Signed 32x32 -> 64-bit multiplier for the datapath ALU.
- Sequential radix-4 Booth (bit-pair recoding) multiplier: one recoded multiplier digit per clock, 16 iteration cycles per product.
- Sits beside the ALU; the control unit pulses start and waits for done before latching the 64-bit result.

---
 rtl/alu_mul.sv | 139 +++++++++++++
 tb/tb_alu_mul.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul.sv
// alu_mul: signed WIDTH x WIDTH -> 2*WIDTH sequential multiplier using
// radix-4 Booth recoding, one recoded multiplier digit per clock
// (WIDTH/2 iteration cycles per product).
//
// Ports:
//   clk    in   system clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request a multiply; sampled only while idle
//   A      in   WIDTH-bit two's complement multiplicand
//   B      in   WIDTH-bit two's complement multiplier
//   P      out  2*WIDTH-bit signed product, held until the next completion
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse in the cycle P is updated
//
// Handshake: start is accepted on a rising edge only while busy=0; A and B
// are captured on that edge and may change afterwards. busy rises on the
// accepting edge and falls on the edge that raises done. A start seen while
// busy=1 is ignored. A new start may be presented in the done cycle.
// WIDTH must be even and at least 4.

module alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int PW    = 2 * WIDTH;
    localparam int ITERS = WIDTH / 2;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;   // sign-extended A, pre-shifted by 2i
    logic [WIDTH:0]     mplier_q, mplier_d; // {B, 0}; low 3 bits are the current triplet
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_sum;
    logic               last_iter;

    // Booth digit selection. mcand_q already carries the 2i shift, so the
    // partial product is added directly; negation is mod 2^PW.
    always_comb begin
        pp = '0;
        unique case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    assign acc_sum   = acc_q + pp;
    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{A[WIDTH-1]}}, A};
                    mplier_d = {B, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    p_d     = acc_sum;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_mul.sv
// tb_alu_mul: self-checking bench for alu_mul. Directed vectors, reset,
// handshake corner cases and random operands checked against a signed
// 64-bit arithmetic reference.

module tb_alu_mul;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] exp_q[$];

    alu_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .P     (p),
        .busy  (busy),
        .done  (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: full signed product in plain integer arithmetic
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // driver: present operands and pulse start across one rising edge (edge n)
    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // count edges until done is seen, bounded
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 40);
        if (!done) check({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
        int cyc;
        logic [63:0] e;
        exp_q.push_back(exp);
        start_op(x, y);
        wait_done(tag, cyc);
        check({tag, " latency"}, 64'(cyc), 64'd16);
        e = exp_q.pop_front();
        check({tag, " P"}, p, e);
        @(posedge clk);
        #1;
        check({tag, " done width"}, 64'(done), 64'd0);
        check({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int cyc2;
        int first_done;
        int n_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] specials[6];

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset P", p, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // directed vectors
        do_op("pos", 32'h1F9, 32'hF0, 64'h000000000001D970);
        do_op("mix1", 32'h8B, 32'hFFFFFF74, 64'hFFFFFFFFFFFFB3FC);
        do_op("mix2", 32'hFFFFFB26, 32'h8C, 64'hFFFFFFFFFFFD58C8);
        do_op("negneg", 32'hFFFFFF10, 32'hFFFFFF7B, 64'h0000000000007CB0);
        do_op("minmin", 32'h80000000, 32'h80000000, 64'h4000000000000000);
        do_op("m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
        do_op("zero", 32'h7FFFFFFF, 32'h0, 64'h0);

        // reset mid-operation aborts with no done pulse
        start_op(32'h1234, 32'h5678);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset P", p, 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("midreset no done", 64'(n_done), 64'd0);

        // start pulsed and operands changed while busy
        start_op(32'hFFFF0123, 32'h00ABCDEF);
        first_done = 0;
        n_done     = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin
                start = 1'b1;
                a     = 32'h7FFFFFFF;
                b     = 32'h80000000;
            end
            if (k == 6) start = 1'b0;
            if (k == 9) a = 32'h0;
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
                if (n_done == 1) check("busyrestart P", p, ref_mul(32'hFFFF0123, 32'h00ABCDEF));
            end
        end
        check("busyrestart latency", 64'(first_done), 64'd16);
        check("busyrestart ndone", 64'(n_done), 64'd1);

        // back-to-back: start asserted in the done cycle
        exp_q.push_back(ref_mul(32'hDEADBEEF, 32'h01234567));
        exp_q.push_back(ref_mul(32'h00000007, 32'hFFFFFFF9));
        start_op(32'hDEADBEEF, 32'h01234567);
        wait_done("b2b first", cyc);
        check("b2b first P", p, exp_q.pop_front());
        a     = 32'h00000007;
        b     = 32'hFFFFFFF9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b second", cyc2);
        check("b2b gap", 64'(cyc2 + 1), 64'd17);
        check("b2b second P", p, exp_q.pop_front());

        // random operands, with occasional corner values
        specials[0] = 32'h0;
        specials[1] = 32'hFFFFFFFF;
        specials[2] = 32'h80000000;
        specials[3] = 32'h7FFFFFFF;
        specials[4] = 32'h1;
        specials[5] = 32'h80000001;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 9) == 0) ra = specials[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) rb = specials[$urandom_range(0, 5)];
            exp_q.push_back(ref_mul(ra, rb));
            start_op(ra, rb);
            wait_done("rand", cyc);
            check("rand P", p, exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
